// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program counter / next-PC generator at the head of the fetch stage
//
// Generates the fetch address for instruction memory: sequential increment on
// each accepted fetch, branch/jump redirect, trap entry, halt/resume, and an
// alignment check on redirect targets (a misaligned target vectors to EXC_VEC).
//
// Ports:
//   clk             in   1      clock, all state changes on rising edge
//   rst             in   1      synchronous reset, active-high
//   redirect_valid  in   1      branch/jump taken this cycle
//   redirect_target in   XLEN   redirect destination
//   trap_valid      in   1      trap/interrupt entry this cycle
//   trap_vector     in   XLEN   trap handler address (low bits forced aligned)
//   halt_req        in   1      stop fetching (RUN -> HALT)
//   resume_req      in   1      leave HALT with pc unchanged
//   fetch_ready     in   1      fetch stage accepts pc_out this cycle
//   pc_out          out  XLEN   current fetch PC
//   pc_valid        out  1      pc_out is a valid fetch request (state RUN)
//   misalign_exc    out  1      one-cycle pulse after a misaligned redirect
//   misalign_addr   out  XLEN   last offending redirect target
//   state_out       out  2      0 = BOOT, 1 = RUN, 2 = HALT
//   fetch_count     out  CNT_W  completed handshakes (wraps)
// -----------------------------------------------------------------------------
module pc_unit #(
   parameter int unsigned     XLEN      = 64,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter logic [XLEN-1:0] EXC_VEC   = XLEN'('h100),
   parameter int unsigned     IALIGN    = 32,
   parameter int unsigned     INC       = 4,
   parameter int unsigned     CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_target,
   input  logic             trap_valid,
   input  logic [XLEN-1:0]  trap_vector,
   input  logic             halt_req,
   input  logic             resume_req,
   input  logic             fetch_ready,
   output logic [XLEN-1:0]  pc_out,
   output logic             pc_valid,
   output logic             misalign_exc,
   output logic [XLEN-1:0]  misalign_addr,
   output logic [1:0]       state_out,
   output logic [CNT_W-1:0] fetch_count
);

   // Low address bits that must be zero for a legal instruction address.
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN / 8 - 1);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t state;
   logic   handshake;

   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return (addr & ALIGN_MASK) != '0;
   endfunction

   function automatic logic [XLEN-1:0] align_down(input logic [XLEN-1:0] addr);
      return addr & ~ALIGN_MASK;
   endfunction

   // Both flags are decoded straight from the state register, so they
   // change only on a clock edge.
   assign pc_valid  = (state == ST_RUN);
   assign state_out = state;
   assign handshake = pc_valid && fetch_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_BOOT;
         pc_out        <= RESET_VEC;
         misalign_exc  <= 1'b0;
         misalign_addr <= '0;
         fetch_count   <= '0;
      end else begin
         // Exception flag is a pulse; only the misaligned-redirect branch sets it.
         misalign_exc <= 1'b0;
         case (state)
            ST_BOOT: begin
               state  <= ST_RUN;
               pc_out <= RESET_VEC;
            end
            ST_RUN: begin
               // Counted even when a trap or redirect overrides the next PC.
               if (handshake)
                  fetch_count <= fetch_count + CNT_W'(1);
               if (trap_valid) begin
                  pc_out <= align_down(trap_vector);
               end else if (redirect_valid) begin
                  if (is_misaligned(redirect_target)) begin
                     pc_out        <= EXC_VEC;
                     misalign_exc  <= 1'b1;
                     misalign_addr <= redirect_target;
                  end else begin
                     pc_out <= redirect_target;
                  end
               end else if (handshake) begin
                  pc_out <= pc_out + XLEN'(INC);
               end
               // A trap in the same cycle keeps the core running.
               if (halt_req && !trap_valid)
                  state <= ST_HALT;
            end
            ST_HALT: begin
               // Redirects are dropped while halted; trap wins over resume.
               if (trap_valid) begin
                  pc_out <= align_down(trap_vector);
                  state  <= ST_RUN;
               end else if (resume_req) begin
                  state <= ST_RUN;
               end
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

endmodule
